// File: rtl/cell_color_pkg.sv
// cell_color_pkg: shared RGB332 definitions for the cell colour pipeline.
//   R_W/G_W/B_W   : RGB332 field widths
//   COLOR_BLACK   : blanking colour
//   COLOR_WHITE   : full-scale colour
//   pack_rgb332() : assembles {r, g, b} into one byte
package cell_color_pkg;

    localparam int unsigned R_W = 3;
    localparam int unsigned G_W = 3;
    localparam int unsigned B_W = 2;

    localparam logic [7:0] COLOR_BLACK = 8'h00;
    localparam logic [7:0] COLOR_WHITE = 8'hFF;

    function automatic logic [7:0] pack_rgb332(input logic [R_W-1:0] r,
                                               input logic [G_W-1:0] g,
                                               input logic [B_W-1:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: emits one pulse for every DIV enabled ticks.
//   clk    in  : system clock
//   reset  in  : synchronous, active-high reset (count -> 0)
//   enable in  : 1 = ticks are counted, 0 = count holds
//   tick   in  : event to be counted
//   pulse  out : combinational, high on the tick that completes a group of DIV
module tick_divider #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic tick,
    output logic pulse
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            step;

    always_comb begin
        step  = enable & tick;
        pulse = step && (cnt_q == CntLast);
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = pulse ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cell_color_pipeline.sv
// cell_color_pipeline: maps a grid cell (x, y, alive) to an RGB332 colour in a
// two-stage registered pipeline with frame-driven gradient scrolling.
//   clk        in  : system clock
//   reset      in  : synchronous, active-high reset
//   in_valid   in  : qualifies x_index / y_index / alive
//   x_index    in  : cell column (X_WIDTH)
//   y_index    in  : cell row (Y_WIDTH)
//   alive      in  : cell state
//   frame_tick in  : one-cycle pulse per video frame
//   scroll_en  in  : 1 = gradient scrolls, 0 = offset frozen
//   out_valid  out : in_valid delayed by two cycles
//   color      out : RGB332 {r[2:0], g[2:0], b[1:0]}, held while out_valid = 0
// Optional build macro CELL_COLOR_CURSOR_EN adds cursor_x / cursor_y ports and
// BLINK_DIV / CURSOR_COLOR parameters for a blinking cursor overlay.
module cell_color_pipeline
    import cell_color_pkg::*;
#(
    parameter int unsigned X_WIDTH    = 5,
    parameter int unsigned Y_WIDTH    = 5,
    parameter int unsigned X_CELLS    = 32,
    parameter int unsigned Y_CELLS    = 24,
    parameter int unsigned SCROLL_DIV = 4,
    parameter logic [7:0]  BG_COLOR   = 8'h00
`ifdef CELL_COLOR_CURSOR_EN
    ,
    parameter int unsigned BLINK_DIV    = 16,
    parameter logic [7:0]  CURSOR_COLOR = 8'hFF
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [X_WIDTH-1:0] x_index,
    input  logic [Y_WIDTH-1:0] y_index,
    input  logic               alive,
    input  logic               frame_tick,
    input  logic               scroll_en,
`ifdef CELL_COLOR_CURSOR_EN
    input  logic [X_WIDTH-1:0] cursor_x,
    input  logic [Y_WIDTH-1:0] cursor_y,
`endif
    output logic               out_valid,
    output logic [7:0]         color
);

    // ------------------------------------------------------------------
    // Gradient offset
    // ------------------------------------------------------------------
    logic [7:0] offset_q, offset_d;
    logic       scroll_pulse;

    tick_divider #(
        .DIV (SCROLL_DIV)
    ) u_scroll_div (
        .clk    (clk),
        .reset  (reset),
        .enable (scroll_en),
        .tick   (frame_tick),
        .pulse  (scroll_pulse)
    );

    // 8-bit add wraps 255 -> 0 on its own.
    always_comb begin
        offset_d = offset_q + {7'd0, scroll_pulse};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            offset_q <= 8'h00;
        end else begin
            offset_q <= offset_d;
        end
    end

`ifdef CELL_COLOR_CURSOR_EN
    // Blink phase runs off every frame, independent of scroll_en.
    logic phase_q, phase_d;
    logic blink_pulse;

    tick_divider #(
        .DIV (BLINK_DIV)
    ) u_blink_div (
        .clk    (clk),
        .reset  (reset),
        .enable (1'b1),
        .tick   (frame_tick),
        .pulse  (blink_pulse)
    );

    always_comb begin
        phase_d = phase_q ^ blink_pulse;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stage 1: shift indices by the current (pre-update) offset
    // ------------------------------------------------------------------
    logic               s1_valid_q, s1_valid_d;
    logic [X_WIDTH-1:0] s1_rx_q, s1_rx_d;
    logic [Y_WIDTH-1:0] s1_gy_q, s1_gy_d;
    logic [B_W-1:0]     s1_b_q, s1_b_d;
    logic               s1_alive_q, s1_alive_d;
    logic               s1_range_q, s1_range_d;
`ifdef CELL_COLOR_CURSOR_EN
    logic               s1_cursor_q, s1_cursor_d;
`endif

    always_comb begin
        s1_valid_d = in_valid;
        s1_rx_d    = s1_rx_q;
        s1_gy_d    = s1_gy_q;
        s1_b_d     = s1_b_q;
        s1_alive_d = s1_alive_q;
        s1_range_d = s1_range_q;
`ifdef CELL_COLOR_CURSOR_EN
        s1_cursor_d = s1_cursor_q;
`endif
        if (in_valid) begin
            // Sized casts make the add wrap modulo 2^WIDTH.
            s1_rx_d    = x_index + X_WIDTH'(offset_q);
            s1_gy_d    = y_index + Y_WIDTH'(offset_q);
            s1_b_d     = offset_q[7:6];
            s1_alive_d = alive;
            // Range is judged on the unshifted index.
            s1_range_d = (32'(x_index) < X_CELLS) && (32'(y_index) < Y_CELLS);
`ifdef CELL_COLOR_CURSOR_EN
            s1_cursor_d = phase_q && (x_index == cursor_x) && (y_index == cursor_y);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_rx_q    <= '0;
            s1_gy_q    <= '0;
            s1_b_q     <= '0;
            s1_alive_q <= 1'b0;
            s1_range_q <= 1'b0;
`ifdef CELL_COLOR_CURSOR_EN
            s1_cursor_q <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_rx_q    <= s1_rx_d;
            s1_gy_q    <= s1_gy_d;
            s1_b_q     <= s1_b_d;
            s1_alive_q <= s1_alive_d;
            s1_range_q <= s1_range_d;
`ifdef CELL_COLOR_CURSOR_EN
            s1_cursor_q <= s1_cursor_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour select
    // ------------------------------------------------------------------
    logic       out_valid_q, out_valid_d;
    logic [7:0] color_q, color_d;
    logic [7:0] color_sel;

    // Priority: out-of-range blanking, then cursor, then dead background.
    always_comb begin
        color_sel = pack_rgb332(s1_rx_q[X_WIDTH-1 -: R_W], s1_gy_q[Y_WIDTH-1 -: G_W], s1_b_q);
        if (!s1_range_q) begin
            color_sel = COLOR_BLACK;
`ifdef CELL_COLOR_CURSOR_EN
        end else if (s1_cursor_q) begin
            color_sel = CURSOR_COLOR;
`endif
        end else if (!s1_alive_q) begin
            color_sel = BG_COLOR;
        end
    end

    always_comb begin
        out_valid_d = s1_valid_q;
        color_d     = s1_valid_q ? color_sel : color_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            color_q     <= COLOR_BLACK;
        end else begin
            out_valid_q <= out_valid_d;
            color_q     <= color_d;
        end
    end

    assign out_valid = out_valid_q;
    assign color     = color_q;

endmodule

// File: tb/tb_cell_color_pipeline.sv
// tb_cell_color_pipeline: table-driven vectors plus a randomised raster sweep
// with a mid-sweep reset; expected colours flow through a scoreboard queue.
module tb_cell_color_pipeline;

    localparam int SCROLL_DIV = 4;
    localparam int NVEC       = 13;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [4:0] x_index;
    logic [4:0] y_index;
    logic       alive;
    logic       frame_tick;
    logic       scroll_en;
    logic       out_valid;
    logic [7:0] color;

    cell_color_pipeline dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .x_index    (x_index),
        .y_index    (y_index),
        .alive      (alive),
        .frame_tick (frame_tick),
        .scroll_en  (scroll_en),
        .out_valid  (out_valid),
        .color      (color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] x;
        logic [4:0] y;
        logic       a;
        int         pre_ticks;
        logic       scroll;
        logic       tick_with;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[NVEC];
    logic [7:0] sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         eff      = 0;  // effective (scroll-enabled) frame ticks since reset

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] model_color(input int x, input int y, input logic a,
                                               input int ticks);
        int         off;
        logic [7:0] o8;
        logic [4:0] rx, gy;
        off = (ticks / SCROLL_DIV) % 256;
        o8  = 8'(off);
        if (x >= 32 || y >= 24) return 8'h00;
        if (!a) return 8'h00;
        rx = 5'((x + off) % 32);
        gy = 5'((y + off) % 32);
        return {rx[4:2], gy[4:2], o8[7:6]};
    endfunction

    // One cycle of stimulus, applied on the falling edge.
    task automatic drive(input logic v, input logic [4:0] x, input logic [4:0] y,
                         input logic a, input logic t, input logic se, input logic [7:0] exp);
        @(negedge clk);
        reset      = 1'b0;
        in_valid   = v;
        x_index    = x;
        y_index    = y;
        alive      = a;
        frame_tick = t;
        scroll_en  = se;
        if (v) sb.push_back(exp);
        if (t && se) eff++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        in_valid   = 1'b0;
        frame_tick = 1'b0;
        sb.delete();
        eff = 0;
    endtask

    // Monitor: out_valid against a 2-deep valid model, colour against scoreboard.
    initial begin : monitor
        logic       ev1, ev2, r, iv;
        logic [7:0] last, e;
        ev1  = 1'b0;
        ev2  = 1'b0;
        last = 8'h00;
        forever begin
            @(posedge clk);
            r   = reset;
            iv  = in_valid;
            ev2 = r ? 1'b0 : ev1;
            ev1 = r ? 1'b0 : iv;
            #1;
            check8("out_valid", {7'd0, out_valid}, {7'd0, ev2});
            if (r) last = 8'h00;
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_empty: got out_valid=1, expected no output at %0t",
                             $time);
                end else begin
                    e = sb.pop_front();
                    check8("color", color, e);
                    last = e;
                end
            end else begin
                check8("color_hold", color, last);
            end
        end
    end

    initial begin : stim
        int pos;
        int cyc;
        logic v, t, a;
        vecs[0]  = '{5'd20, 5'd12, 1'b1, 0,   1'b1, 1'b0, 8'hAC};
        vecs[1]  = '{5'd20, 5'd12, 1'b0, 0,   1'b1, 1'b0, 8'h00};
        vecs[2]  = '{5'd20, 5'd24, 1'b1, 0,   1'b1, 1'b0, 8'h00};
        vecs[3]  = '{5'd31, 5'd23, 1'b1, 0,   1'b1, 1'b0, 8'hF4};
        vecs[4]  = '{5'd0,  5'd0,  1'b1, 0,   1'b1, 1'b0, 8'h00};
        vecs[5]  = '{5'd30, 5'd5,  1'b1, 8,   1'b1, 1'b0, 8'h04};  // offset 2, rx wraps
        vecs[6]  = '{5'd30, 5'd5,  1'b1, 10,  1'b0, 1'b0, 8'h04};  // frozen
        vecs[7]  = '{5'd29, 5'd5,  1'b1, 0,   1'b1, 1'b0, 8'hE4};
        vecs[8]  = '{5'd0,  5'd0,  1'b1, 760, 1'b1, 1'b0, 8'h03};  // 768 ticks: offset 192
        vecs[9]  = '{5'd4,  5'd8,  1'b1, 0,   1'b1, 1'b0, 8'h2B};
        vecs[10] = '{5'd20, 5'd12, 1'b1, 256, 1'b1, 1'b0, 8'hAC};  // 1024 ticks: offset 0
        vecs[11] = '{5'd31, 5'd7,  1'b1, 3,   1'b1, 1'b1, 8'hE4};  // tick with cell: old offset
        vecs[12] = '{5'd31, 5'd7,  1'b1, 0,   1'b1, 1'b0, 8'h08};  // next cell: offset 1

        reset      = 1'b1;
        in_valid   = 1'b0;
        x_index    = '0;
        y_index    = '0;
        alive      = 1'b0;
        frame_tick = 1'b0;
        scroll_en  = 1'b0;
        repeat (3) @(negedge clk);

        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < NVEC; i++) begin
            for (int k = 0; k < vecs[i].pre_ticks; k++) begin
                drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, vecs[i].scroll, 8'h00);
            end
            drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].a, vecs[i].tick_with, vecs[i].scroll,
                  vecs[i].exp);
        end
        repeat (3) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Raster sweep with random gaps, random frame ticks and a mid-sweep reset.
        pos = 0;
        cyc = 0;
        while (pos < 768) begin
            if (cyc == 300) do_reset();
            v = 1'($urandom_range(0, 1));
            t = ($urandom_range(0, 7) == 0);
            a = 1'($urandom_range(0, 1));
            drive(v, 5'(pos % 32), 5'(pos / 32), a, t, 1'b1,
                  model_color(pos % 32, pos / 32, a, eff));
            if (v) pos++;
            cyc++;
        end
        repeat (4) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);

        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cell_color_pipeline.md
Name: cell_color_pipeline

Overview:
- Parametrised successor to the combinational cell colour generator for the life-game display.
- Maps a grid cell index plus its alive bit to an RGB332 colour through a 2-stage registered pipeline.
- Adds frame-driven gradient scrolling, a dead-cell background colour and out-of-range blanking.
- Sits between the cell-state readout and the VGA pixel path; streams one cell per cycle with no backpressure.

Parameters:
- X_WIDTH, 5, width of the x cell index (must be >= 3).
- Y_WIDTH, 5, width of the y cell index (must be >= 3).
- X_CELLS, 32, number of valid columns; x_index >= X_CELLS is out of range.
- Y_CELLS, 24, number of valid rows; y_index >= Y_CELLS is out of range.
- SCROLL_DIV, 4, number of frame_tick pulses per offset increment (>= 1).
- BG_COLOR, 8'h00, colour emitted for dead in-range cells.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies x_index/y_index/alive this cycle.
- x_index  in  X_WIDTH  cell column.
- y_index  in  Y_WIDTH  cell row.
- alive  in  1  cell state.
- frame_tick  in  1  one-cycle pulse per video frame.
- scroll_en  in  1  1 = gradient scrolls, 0 = offset frozen.
- out_valid  out  1  qualifies color.
- color  out  8  RGB332 {r[2:0], g[2:0], b[1:0]}.

Behaviour:
- One clock domain; reset is synchronous and active-high. The clock is clk and the reset is reset.
- Reset values: out_valid=0, color=8'h00, offset=0, scroll divider=0, all pipeline valid bits=0.
- Reset asserted mid-stream discards in-flight cells; out_valid is 0 on the cycle after reset is sampled high.
- Latency: in_valid high at edge N gives out_valid high at edge N+2. Throughput is 1 per cycle. out_valid is a delayed copy of in_valid.
- color is held when out_valid=0.
- Stage 1 registers:
  - rx = (x_index + offset[X_WIDTH-1:0]) mod 2^X_WIDTH
  - gy = (y_index + offset[Y_WIDTH-1:0]) mod 2^Y_WIDTH
  - b = offset[7:6]
  - alive
  - range_ok = (x_index < X_CELLS) && (y_index < Y_CELLS), computed on the unshifted index.
- Stage 2 output colour:
  - range_ok=0 -> 8'h00.
  - Otherwise alive=0 -> BG_COLOR.
  - Otherwise {rx[X_WIDTH-1 -: 3], gy[Y_WIDTH-1 -: 3], b}.
- Scroll divider:
  - An 8-bit offset register plus a divider counter.
  - On frame_tick with scroll_en=1: divider increments. When it reaches SCROLL_DIV-1 it clears and offset increments, wrapping 255 -> 0.
  - With scroll_en=0 both the divider and offset hold. Deasserting and reasserting scroll_en resumes from the held divider value.
- frame_tick coincident with in_valid: that cell uses the pre-update offset. The new offset applies to cells entering on the next cycle.

Optional Feature:
- Macro: CELL_COLOR_CURSOR_EN.
- When defined:
  - Adds ports cursor_x (in, X_WIDTH) and cursor_y (in, Y_WIDTH).
  - Adds parameters BLINK_DIV (default 16) and CURSOR_COLOR (default 8'hFF).
  - A blink phase bit (reset 0) toggles every BLINK_DIV frame_ticks, regardless of scroll_en.
  - When an in-range cell matches the cursor (cursor sampled in stage 1) and phase=1, color=CURSOR_COLOR, overriding alive/BG_COLOR.
  - Out-of-range blanking still has priority over the cursor.
- When undefined: cursor ports, parameters and blink logic are absent; behaviour is exactly as above.

Decomposition:
- Package cell_color_pkg holds:
  - RGB332 field widths (R_W=3, G_W=3, B_W=2).
  - Constants COLOR_BLACK=8'h00 and COLOR_WHITE=8'hFF.
  - A pack_rgb332 function.
- One sub-module, tick_divider (parameter DIV; inputs clk, reset, enable, tick; output pulse):
  - Drives the offset increment.
  - Is instantiated a second time for blink under CELL_COLOR_CURSOR_EN.

Test Plan:
- Reset, then x=20, y=12, alive=1, offset 0 -> out_valid exactly 2 cycles later with color=8'hAC.
- Same cell with alive=0 -> color=BG_COLOR (8'h00); out-of-range x=20, y=24, alive=1 -> 8'h00.
- scroll_en=1, 8 frame_ticks (offset=2), then x=30, y=5, alive=1 -> rx wraps to 0 -> color=8'h04.
- scroll_en=0 for 10 ticks -> offset unchanged; re-enable with 768 total effective ticks -> offset=192, b=2'b11; 1024 ticks -> offset wraps to 0.
- Continuous 32x24 raster sweep with in_valid toggled randomly and reset pulsed mid-sweep -> out_valid matches in_valid delayed by 2, and is 0 the cycle after reset.
- With CELL_COLOR_CURSOR_EN, cursor=(3,4), BLINK_DIV=2 -> cell (3,4) is 8'hFF only while phase=1, toggling every 2 frame_ticks.
